// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the memory refill arbiter: port IDs, route FIFO sizing, 16B memory messages.
package mem_refill_arbiter_pkg;

   typedef logic port_id_t;

   localparam int p_inflight_default = 4;
   localparam int route_fifo_depth   = p_inflight_default;

   typedef enum logic [2:0] {
      MEM_READ       = 3'd0,
      MEM_WRITE      = 3'd1,
      MEM_WRITE_INIT = 3'd2
   } mem_type_t;

   // Field layout of the 16B request/response messages used by the caches and main memory.
   typedef struct packed {
      mem_type_t      mtype;
      logic [7:0]     opaque;
      logic [31:0]    addr;
      logic [3:0]     len;
      logic [127:0]   data;
   } mem_req_16B_t;

   typedef struct packed {
      mem_type_t      mtype;
      logic [7:0]     opaque;
      logic [1:0]     test;
      logic [3:0]     len;
      logic [127:0]   data;
   } mem_resp_16B_t;

endpackage

// File: rtl/mem_refill_arbiter_route.sv
// mem_route_fifo: p_depth x 1b FIFO holding the issuing port of each outstanding memory request.
module mem_route_fifo
   import mem_refill_arbiter_pkg::*;
#(
   parameter int p_depth = route_fifo_depth
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     push,
   input  port_id_t push_data,
   input  logic     pop,
   output port_id_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int aw = $clog2(p_depth);
   localparam int cw = aw + 1;

   logic [p_depth-1:0] slots;
   logic [aw-1:0]      head;
   logic [aw-1:0]      tail;
   logic [cw-1:0]      count;
   logic               push_ok;
   logic               pop_ok;

   assign full     = (count == cw'(p_depth));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = slots[head];

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slots <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            slots[tail] <= push_data;
            tail        <= tail + aw'(1);
         end
         if (pop_ok)
            head <= head + aw'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + cw'(1);
            2'b01:   count <= count - cw'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin merge of icache/dcache memory requests with in-order response routing.
// Optional MEM_REFILL_ARBITER_PERF_EN adds grant and full-stall counters.
module mem_refill_arbiter
   import mem_refill_arbiter_pkg::*;
#(
   parameter int p_inflight = p_inflight_default
) (
   input  logic          clk,
   input  logic          reset,

   input  mem_req_16B_t  cache0_memreq_msg,
   input  logic          cache0_memreq_val,
   output logic          cache0_memreq_rdy,
   output mem_resp_16B_t cache0_memresp_msg,
   output logic          cache0_memresp_val,
   input  logic          cache0_memresp_rdy,

   input  mem_req_16B_t  cache1_memreq_msg,
   input  logic          cache1_memreq_val,
   output logic          cache1_memreq_rdy,
   output mem_resp_16B_t cache1_memresp_msg,
   output logic          cache1_memresp_val,
   input  logic          cache1_memresp_rdy,

   output mem_req_16B_t  memreq_msg,
   output logic          memreq_val,
   input  logic          memreq_rdy,
   input  mem_resp_16B_t memresp_msg,
   input  logic          memresp_val,
   output logic          memresp_rdy
`ifdef MEM_REFILL_ARBITER_PERF_EN
   ,
   output logic [31:0]   perf_grant0,
   output logic [31:0]   perf_grant1,
   output logic [31:0]   perf_full_stall
`endif
);

   port_id_t prio;
   port_id_t grant;
   logic     grant_vld;
   logic     issue_ok;
   logic     req_fire;
   port_id_t dst;
   logic     fifo_full;
   logic     fifo_empty;
   logic     resp_fire;

   always_comb begin
      grant     = prio;
      grant_vld = 1'b0;
      if (prio ? cache1_memreq_val : cache0_memreq_val) begin
         grant     = prio;
         grant_vld = 1'b1;
      end else if (prio ? cache0_memreq_val : cache1_memreq_val) begin
         grant     = ~prio;
         grant_vld = 1'b1;
      end
   end

   // Reset gates the request side directly; the response side is already quiet
   // because the FIFO count clears asynchronously.
   assign issue_ok          = grant_vld && !fifo_full && !reset;
   assign memreq_val        = issue_ok;
   assign memreq_msg        = grant ? cache1_memreq_msg : cache0_memreq_msg;
   assign req_fire          = issue_ok && memreq_rdy;
   assign cache0_memreq_rdy = req_fire && (grant == 1'b0);
   assign cache1_memreq_rdy = req_fire && (grant == 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prio <= 1'b0;
      else if (req_fire)
         prio <= ~grant;
   end

   assign cache0_memresp_msg = memresp_msg;
   assign cache1_memresp_msg = memresp_msg;
   assign cache0_memresp_val = memresp_val && !fifo_empty && (dst == 1'b0);
   assign cache1_memresp_val = memresp_val && !fifo_empty && (dst == 1'b1);
   assign memresp_rdy        = !fifo_empty && (dst ? cache1_memresp_rdy : cache0_memresp_rdy);
   assign resp_fire          = memresp_val && memresp_rdy;

   mem_route_fifo #(.p_depth(p_inflight)) route_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (grant),
      .pop       (resp_fire),
      .pop_data  (dst),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef MEM_REFILL_ARBITER_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_grant0     <= '0;
         perf_grant1     <= '0;
         perf_full_stall <= '0;
      end else begin
         if (cache0_memreq_rdy)
            perf_grant0 <= perf_grant0 + 32'd1;
         if (cache1_memreq_rdy)
            perf_grant1 <= perf_grant1 + 32'd1;
         if ((cache0_memreq_val || cache1_memreq_val) && fifo_full)
            perf_full_stall <= perf_full_stall + 32'd1;
      end
   end
`endif

endmodule
